// File: rtl/mmx_count_display.sv
// Captures a 7-bit value, converts it to BCD with a sequential double-dabble engine and scans the
// three digits onto one multiplexed 7-segment display. Define MMX_DISP_BLANK_EN for leading-zero blanking.
module mmx_count_display #(
    parameter int VALUE_W        = 7,
    parameter int REFRESH_DIV    = 1024,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [VALUE_W-1:0] in_value,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               done,
    output logic [11:0]        bcd_out,
    output logic [6:0]         seg,
    output logic [2:0]         digit_en
);

    localparam int                CNT_W      = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [2:0]        SHIFT_LAST = 3'(VALUE_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_COMMIT
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_accept;
    logic [2:0]         r_shift_cnt;
    logic [VALUE_W-1:0] r_bin;
    logic [11:0]        r_scratch;
    logic [11:0]        w_adj;
    logic [11:0]        r_bcd;
    logic               r_done;
    logic [CNT_W-1:0]   r_refresh;
    logic [1:0]         r_idx;
    logic [3:0]         w_digit;
    logic [6:0]         w_seg_raw;
    logic [2:0]         w_en_raw;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h3F;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5B;
            4'd3:    seg7 = 7'h4F;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6D;
            4'd6:    seg7 = 7'h7D;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT:  if (r_shift_cnt == SHIFT_LAST) w_state_nxt = S_COMMIT;
            S_COMMIT: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Add-3 correction is applied to every nibble before the shift in the same cycle.
    always_comb begin
        w_adj = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            w_adj[4*i +: 4] = (r_scratch[4*i +: 4] >= 4'd5) ? r_scratch[4*i +: 4] + 4'd3
                                                            : r_scratch[4*i +: 4];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift_cnt <= '0;
            r_bin       <= '0;
            r_scratch   <= '0;
            r_bcd       <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= (r_state == S_COMMIT);
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_bin       <= in_value;
                        r_scratch   <= '0;
                        r_shift_cnt <= '0;
                    end
                end
                S_SHIFT: begin
                    r_scratch   <= {w_adj[10:0], r_bin[VALUE_W-1]};
                    r_bin       <= {r_bin[VALUE_W-2:0], 1'b0};
                    r_shift_cnt <= r_shift_cnt + 3'd1;
                end
                S_COMMIT: r_bcd <= r_scratch;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_refresh <= '0;
            r_idx     <= '0;
        end else if (r_refresh == CNT_LAST) begin
            r_refresh <= '0;
            r_idx     <= (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;
        end else begin
            r_refresh <= r_refresh + 1'b1;
        end
    end

    // Decode straight from the committed digits so a commit on a wrap edge shows immediately.
    always_comb begin
        w_digit  = r_bcd[3:0];
        w_en_raw = 3'b001;
        case (r_idx)
            2'd1: begin
                w_digit  = r_bcd[7:4];
                w_en_raw = 3'b010;
            end
            2'd2: begin
                w_digit  = r_bcd[11:8];
                w_en_raw = 3'b100;
            end
            default: ;
        endcase
        w_seg_raw = seg7(w_digit);
`ifdef MMX_DISP_BLANK_EN
        if (r_idx == 2'd2 && r_bcd[11:8] == 4'd0)
            w_seg_raw = '0;
        if (r_idx == 2'd1 && r_bcd[11:8] == 4'd0 && r_bcd[7:4] == 4'd0)
            w_seg_raw = '0;
`else
        w_seg_raw = w_seg_raw;
`endif
    end

    assign in_ready = (r_state == S_IDLE) && !reset;
    assign done     = r_done;
    assign bcd_out  = r_bcd;
    assign seg      = SEG_ACTIVE_LOW ? ~w_seg_raw : w_seg_raw;
    assign digit_en = SEG_ACTIVE_LOW ? ~w_en_raw : w_en_raw;

endmodule

// File: tb/tb_mmx_count_display.sv
// Directed bench for mmx_count_display: three instances share one stimulus stream
// (default, fast refresh, fast refresh with inverted outputs).
module tb_mmx_count_display;

`ifdef MMX_DISP_BLANK_EN
    localparam logic [6:0] LEAD = 7'h00;
`else
    localparam logic [6:0] LEAD = 7'h3F;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  in_value;
    logic        in_valid;

    logic        a_ready, a_done;
    logic [11:0] a_bcd;
    logic [6:0]  a_seg;
    logic [2:0]  a_en;
    logic        f_ready, f_done;
    logic [11:0] f_bcd;
    logic [6:0]  f_seg;
    logic [2:0]  f_en;
    logic        v_ready, v_done;
    logic [11:0] v_bcd;
    logic [6:0]  v_seg;
    logic [2:0]  v_en;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mmx_count_display u_dut (
        .clk(clk), .reset(reset), .in_value(in_value), .in_valid(in_valid),
        .in_ready(a_ready), .done(a_done), .bcd_out(a_bcd), .seg(a_seg), .digit_en(a_en)
    );

    mmx_count_display #(.REFRESH_DIV(4)) u_fast (
        .clk(clk), .reset(reset), .in_value(in_value), .in_valid(in_valid),
        .in_ready(f_ready), .done(f_done), .bcd_out(f_bcd), .seg(f_seg), .digit_en(f_en)
    );

    mmx_count_display #(.REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b1)) u_inv (
        .clk(clk), .reset(reset), .in_value(in_value), .in_valid(in_valid),
        .in_ready(v_ready), .done(v_done), .bcd_out(v_bcd), .seg(v_seg), .digit_en(v_en)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // which: 0 = u_dut, 1 = u_fast
    task automatic wait_en(input int which, input logic [2:0] target, input int limit, input string tag);
        int   k;
        logic hit;
        hit = 1'b0;
        for (k = 0; k < limit; k++) begin
            if ((which == 0 ? a_en : f_en) === target) begin
                hit = 1'b1;
                break;
            end
            tick();
        end
        check(tag, {11'd0, hit}, 12'd1);
    endtask

    initial begin
        logic [6:0] exp_seg;
        logic [6:0] inv_seg;
        logic [2:0] exp_en;
        logic [2:0] inv_en;
        int         idx;

        reset    = 1'b1;
        in_valid = 1'b0;
        in_value = '0;

        // 1: reset state
        tick();
        tick();
        check("rst_ready", {11'd0, a_ready}, 12'd0);
        check("rst_en",    {9'd0, a_en},     12'h001);
        check("rst_seg",   {5'd0, a_seg},    12'h03F);
        check("rst_bcd",   a_bcd,            12'h000);
        check("rst_done",  {11'd0, a_done},  12'd0);
        check("rst_inv_en",  {9'd0, v_en},   12'h006);
        check("rst_inv_seg", {5'd0, v_seg},  12'h040);
        reset = 1'b0;
        tick();
        check("post_rst_ready", {11'd0, a_ready}, 12'd1);

        // 2: value 127, latency and scan
        in_value = 7'd127;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("c127_ready_e0", {11'd0, a_ready}, 12'd0);
        for (int e = 1; e <= 7; e++) begin
            tick();
            check("c127_ready_busy", {11'd0, a_ready}, 12'd0);
            check("c127_done_busy",  {11'd0, a_done},  12'd0);
        end
        tick();
        check("c127_done_e8",  {11'd0, a_done},  12'd1);
        check("c127_bcd",      a_bcd,            12'h127);
        check("c127_ready_e8", {11'd0, a_ready}, 12'd1);
        tick();
        check("c127_done_e9",  {11'd0, a_done},  12'd0);
        wait_en(0, 3'b010, 3100, "scan_wait_tens");
        check("scan_tens_seg", {5'd0, a_seg}, 12'h05B);
        wait_en(0, 3'b100, 3100, "scan_wait_hund");
        check("scan_hund_seg", {5'd0, a_seg}, 12'h006);
        wait_en(0, 3'b001, 3100, "scan_wait_ones");
        check("scan_ones_seg", {5'd0, a_seg}, 12'h007);

        // 3: held valid, value changes mid-conversion
        in_value = 7'd5;
        in_valid = 1'b1;
        tick();
        tick();
        tick();
        tick();
        in_value = 7'd99;
        for (int e = 4; e <= 8; e++) tick();
        check("hold_bcd5",  a_bcd,           12'h005);
        check("hold_done5", {11'd0, a_done}, 12'd1);
        tick();
        check("hold_accept99", {11'd0, a_ready}, 12'd0);
        for (int e = 10; e <= 16; e++) tick();
        check("hold_bcd_pre", a_bcd, 12'h005);
        tick();
        check("hold_bcd99",  a_bcd,           12'h099);
        check("hold_done99", {11'd0, a_done}, 12'd1);
        in_valid = 1'b0;

        // 4: reset aborts a conversion
        tick();
        in_value = 7'd64;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("abort_bcd",   a_bcd,            12'h000);
        check("abort_done",  {11'd0, a_done},  12'd0);
        check("abort_ready", {11'd0, a_ready}, 12'd0);
        reset = 1'b0;
        for (int e = 0; e < 8; e++) begin
            tick();
            check("abort_no_done", {11'd0, a_done},  12'd0);
            check("abort_idle",    {11'd0, a_ready}, 12'd1);
        end
        check("abort_bcd_after", a_bcd, 12'h000);
        check("abort_en",        {9'd0, a_en}, 12'h001);

        // 5: fast refresh scan and commit on a wrap edge
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int n = 1; n <= 11; n++) begin
            tick();
            idx    = (n / 4) % 3;
            exp_en = 3'b001 << idx;
            check("fast_scan_en", {9'd0, f_en}, {9'd0, exp_en});
        end
        in_value = 7'd127;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("fast_wrap_en12", {9'd0, f_en},     12'h001);
        check("fast_accept",    {11'd0, f_ready}, 12'd0);
        for (int n = 13; n <= 19; n++) begin
            tick();
            idx    = (n / 4) % 3;
            exp_en = 3'b001 << idx;
            check("fast_busy_en", {9'd0, f_en}, {9'd0, exp_en});
        end
        check("fast_old_tens", {5'd0, f_seg}, {5'd0, LEAD});
        tick();
        check("fast_commit_en",   {9'd0, f_en},    12'h004);
        check("fast_commit_seg",  {5'd0, f_seg},   12'h006);
        check("fast_commit_done", {11'd0, f_done}, 12'd1);
        check("fast_commit_bcd",  f_bcd,           12'h127);
        check("inv_commit_en",    {9'd0, v_en},    12'h003);
        check("inv_commit_seg",   {5'd0, v_seg},   12'h079);

        // 6: value 5, leading digits and polarity
        in_value = 7'd5;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int e = 1; e <= 8; e++) tick();
        check("v5_bcd", f_bcd, 12'h005);
        wait_en(1, 3'b100, 16, "v5_wait_hund");
        wait_en(1, 3'b001, 16, "v5_wait_ones");
        for (int k = 0; k < 12; k++) begin
            idx     = (k / 4) % 3;
            exp_en  = 3'b001 << idx;
            exp_seg = (idx == 0) ? 7'h6D : LEAD;
            inv_en  = ~exp_en;
            inv_seg = ~exp_seg;
            check("v5_en",      {9'd0, f_en},  {9'd0, exp_en});
            check("v5_seg",     {5'd0, f_seg}, {5'd0, exp_seg});
            check("v5_inv_en",  {9'd0, v_en},  {9'd0, inv_en});
            check("v5_inv_seg", {5'd0, v_seg}, {5'd0, inv_seg});
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
